// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared Set-2 scancode constants, event layout and receiver
//               state encoding for the PS/2 key tracker.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam logic [7:0] SC_EXT        = 8'hE0;
    localparam logic [7:0] SC_BRK        = 8'hF0;
    localparam logic [7:0] SC_LSHIFT     = 8'h12;
    localparam logic [7:0] SC_RSHIFT     = 8'h59;
    localparam logic [7:0] SC_LCTRL      = 8'h14;
    localparam logic [7:0] SC_ENTER      = 8'h5A;
    localparam logic [7:0] SC_IGNORE_MIN = 8'hE1;

    // Event word: {brk, ext, code[7:0]}
    localparam int EVT_CODE_W   = 8;
    localparam int EVT_CODE_LSB = 0;
    localparam int EVT_EXT_BIT  = 8;
    localparam int EVT_BRK_BIT  = 9;
    localparam int EVT_W        = 10;
    localparam int KEY_ADDR_W   = 9;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    function automatic logic [EVT_W-1:0] make_event(input logic brk, input logic ext,
                                                    input logic [EVT_CODE_W-1:0] code);
        return {brk, ext, code};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx_frame.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_frame
// Description : PS/2 device-to-host receiver: input synchronisers, falling
//               edge detect, 11-bit deframer with odd parity and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int CHECK_PARITY   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       err_parity,
    output logic       err_timeout
);

    localparam int                  c_tmr_w   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [c_tmr_w-1:0]  c_tmr_max = c_tmr_w'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;
    logic                   w_clk_s;
    logic                   w_data_s;
    logic                   w_fall;

    rx_state_t              r_state;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic                   r_par;
    logic [c_tmr_w-1:0]     r_timer;
    logic                   r_byte_valid;
    logic [7:0]             r_byte_data;
    logic                   r_err_parity;
    logic                   r_err_timeout;

    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s = r_data_sync[SYNC_STAGES-1];
    assign w_fall   = r_clk_prev & ~w_clk_s;

    // Idle PS/2 lines are high; resetting to 1 avoids a phantom falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
            r_clk_prev  <= w_clk_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RX_IDLE;
            r_bit_cnt     <= 3'd0;
            r_shift       <= 8'h00;
            r_par         <= 1'b0;
            r_timer       <= '0;
            r_byte_valid  <= 1'b0;
            r_byte_data   <= 8'h00;
            r_err_parity  <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_byte_valid  <= 1'b0;
            r_err_parity  <= 1'b0;
            r_err_timeout <= 1'b0;
            if (w_fall) begin
                r_timer <= '0;
                case (r_state)
                    RX_IDLE: begin
                        r_bit_cnt <= 3'd0;
                        r_par     <= 1'b0;
                        if (!w_data_s) begin
                            r_state <= RX_DATA;
                        end
                    end
                    RX_DATA: begin
                        r_shift   <= {w_data_s, r_shift[7:1]};
                        r_par     <= r_par ^ w_data_s;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= RX_PARITY;
                        end
                    end
                    RX_PARITY: begin
                        r_par   <= r_par ^ w_data_s;
                        r_state <= RX_STOP;
                    end
                    RX_STOP: begin
                        r_state <= RX_IDLE;
                        // r_par now holds XOR over data+parity: 1 means odd.
                        if ((r_par || (CHECK_PARITY == 0)) && w_data_s) begin
                            r_byte_valid <= 1'b1;
                            r_byte_data  <= r_shift;
                        end else begin
                            r_err_parity <= 1'b1;
                        end
                    end
                    default: r_state <= RX_IDLE;
                endcase
            end else if (r_state != RX_IDLE) begin
                if (r_timer == c_tmr_max) begin
                    r_err_timeout <= 1'b1;
                    r_state       <= RX_IDLE;
                    r_timer       <= '0;
                end else begin
                    r_timer <= r_timer + c_tmr_w'(1);
                end
            end
        end
    end

    assign byte_valid  = r_byte_valid;
    assign byte_data   = r_byte_data;
    assign err_parity  = r_err_parity;
    assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: rtl/ps2_key_tracker.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_tracker
// Description : PS/2 keyboard front end: Set-2 make/break/extended decoder,
//               per-key pressed bitmap, modifier status and event FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int FIFO_DEPTH     = 8,
    parameter int CHECK_PARITY   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    input  logic [KEY_ADDR_W-1:0] key_addr,
    output logic                  key_down,
    output logic                  shift_down,
    output logic                  ctrl_down,
    output logic                  evt_valid,
    output logic [EVT_W-1:0]      evt_data,
    input  logic                  evt_ready,
    output logic                  evt_overflow,
    output logic                  err_parity,
    output logic                  err_timeout
);

    localparam int                c_ptr_w = $clog2(FIFO_DEPTH);
    localparam logic [c_ptr_w:0]  c_depth = (c_ptr_w + 1)'(FIFO_DEPTH);

    logic                    w_byte_valid;
    logic [7:0]              w_byte_data;

    logic [(1<<KEY_ADDR_W)-1:0] r_bitmap;
    logic                    r_ext;
    logic                    r_brk;

    logic [EVT_W-1:0]        r_mem [0:FIFO_DEPTH-1];
    logic [c_ptr_w-1:0]      r_wr_ptr;
    logic [c_ptr_w-1:0]      r_rd_ptr;
    logic [c_ptr_w:0]        r_count;
    logic                    r_overflow;

    logic                    r_key_down;
    logic                    r_shift_down;
    logic                    r_ctrl_down;

    logic                    w_is_key;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_push_ok;
    logic [EVT_W-1:0]        w_evt;

    ps2_rx_frame #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CHECK_PARITY   (CHECK_PARITY)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .byte_valid  (w_byte_valid),
        .byte_data   (w_byte_data),
        .err_parity  (err_parity),
        .err_timeout (err_timeout)
    );

    // Prefix bytes and the E1..FF range (pause sequence etc.) are not keys.
    assign w_is_key  = w_byte_valid && (w_byte_data != SC_EXT) &&
                       (w_byte_data < SC_IGNORE_MIN);
    assign w_evt     = make_event(r_brk, r_ext, w_byte_data);
    assign w_full    = (r_count == c_depth);
    assign w_pop     = evt_valid && evt_ready;
    assign w_push_ok = w_is_key && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bitmap <= '0;
            r_ext    <= 1'b0;
            r_brk    <= 1'b0;
        end else if (w_byte_valid) begin
            if (w_byte_data == SC_EXT) begin
                r_ext <= 1'b1;
            end else if (w_byte_data == SC_BRK) begin
                r_brk <= 1'b1;
            end else if (w_byte_data < SC_IGNORE_MIN) begin
                r_bitmap[{r_ext, w_byte_data}] <= ~r_brk;
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_evt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_is_key && w_full && !w_pop;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_down   <= 1'b0;
            r_shift_down <= 1'b0;
            r_ctrl_down  <= 1'b0;
        end else begin
            r_key_down   <= r_bitmap[key_addr];
            r_shift_down <= r_bitmap[{1'b0, SC_LSHIFT}] | r_bitmap[{1'b0, SC_RSHIFT}];
            r_ctrl_down  <= r_bitmap[{1'b0, SC_LCTRL}]  | r_bitmap[{1'b1, SC_LCTRL}];
        end
    end

    assign evt_valid    = (r_count != '0);
    // Head entry is masked so an empty FIFO presents zero, not stale data.
    assign evt_data     = evt_valid ? r_mem[r_rd_ptr] : '0;
    assign evt_overflow = r_overflow;
    assign key_down     = r_key_down;
    assign shift_down   = r_shift_down;
    assign ctrl_down    = r_ctrl_down;

endmodule
`default_nettype wire
